rate_sweep_ctrl: RTL and testbench
==================================

# rate_sweep_ctrl

Sequencer for the selectable-rate tick counter. It drives the counter's 3-bit switch word `{rate_sel[1:0], enable}` and its reset, then steps the rate selection through a programmed sweep. Each rate is held for a fixed number of counter ticks, and the sweep runs in either wrap-up or ping-pong order. It sits between the board buttons/switches and the counter, replacing direct switch wiring.

## Interface
- `TICKS_PER_PHASE`, default 16: counter ticks spent at each rate, legal range 1..2^NB_TICKS.
- `NB_TICKS`, default 8: width of the per-phase tick counter.
- `NB_SWEEP`, default 8: width of the completed-sweep counter.
- `clock` in 1: system clock, rising edge.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_start` in 1: start request, sampled every cycle.
- `i_stop` in 1: stop request, sampled every cycle.
- `i_pause` in 1: level; while high the sweep is frozen.
- `i_mode` in 1: 0 = wrap-up (0,1,2,3,0,...); 1 = ping-pong (0,1,2,3,2,1,0,...). Sampled only when leaving IDLE.
- `i_tick` in 1: counter `o_valid`.
- `o_sw` out 3: to counter `i_sw`; `[2:1]` = rate_sel, `[0]` = enable.
- `o_cnt_reset` out 1: to counter `i_reset`.
- `o_busy` out 1: state is not IDLE.
- `o_phase_done` out 1: one-cycle pulse on every rate change.
- `o_sweep_done` out 1: one-cycle pulse when rate_sel returns to 0.
- `o_sweep_count` out NB_SWEEP: completed sweeps since start; saturates at all-ones.

## Operation
- States:
  - IDLE: enable=0.
  - RUN: enable=1.
  - HOLD: enable=0, all state retained.
- Tick qualification:
  - `tick_d` registers `i_tick` every cycle in every state.
  - tick_edge = `i_tick & ~tick_d`.
  - Only tick_edge in RUN is counted. A held-high `i_tick` never counts twice.
- IDLE:
  - `i_start` → RUN. Same edge: rate_sel=0, dir=up, tick_cnt=0, sweep_count=0, mode latched, `o_cnt_reset`=1 for one cycle.
- RUN:
  - `i_pause` → HOLD.
  - On tick_edge:
    - If tick_cnt < TICKS_PER_PHASE-1: tick_cnt+1.
    - Else: tick_cnt=0, rate_sel advances, `o_phase_done`=1, `o_cnt_reset`=1 (one cycle).
- HOLD:
  - `i_pause` low → RUN, no counter reset.
  - tick_edge is ignored.
- Advance rules:
  - Wrap-up: sel+1 mod 4; sel 3→0 pulses `o_sweep_done`.
  - Ping-pong: dir flips to down on reaching 3 and to up on reaching 0; the 1→0 step pulses `o_sweep_done`.
  - On every sweep_done, sweep_count+1, saturating.
- `i_stop` in any state → IDLE next edge: enable=0, rate_sel=0, tick_cnt=0. sweep_count is held for readback until the next start.
- Priority, highest first: `i_reset` > `i_stop` > `i_start` (IDLE only) > `i_pause` > tick_edge.
  - A tick_edge in the same cycle as pause entry is dropped.
  - `i_start` while busy is ignored; restart requires stop then start.

## Timing
- All outputs are registered. Reset values: state IDLE, `o_sw`=3'b000, `o_cnt_reset`=0, `o_busy`=0, `o_phase_done`=0, `o_sweep_done`=0, `o_sweep_count`=0, `tick_d`=0.
- `o_busy` and `o_sw[0]` rise one cycle after `i_start` is sampled; `o_cnt_reset` is high in that same cycle.
- Phase change latency: the `o_sw[2:1]`, `o_phase_done` and `o_cnt_reset` updates appear one cycle after the qualifying tick_edge cycle.
- The counter is reset during the first cycle of each phase, so every phase spans TICKS_PER_PHASE full periods at its rate.
- Pause and stop take effect on `o_sw[0]` one cycle after sampling.
- Reset mid-sweep returns all outputs to their reset values on the next edge, with no pulses emitted.

## Test plan
- Bench settings: TICKS_PER_PHASE=2. `i_tick` is a 1-cycle pulse every 5 cycles unless noted.
- Reset, then start with `i_mode`=0 → `o_sw` = 001, 011, 101, 111, 001. Each change follows the 2nd tick of its phase. `o_sweep_done` pulses once at 111→001. `o_sweep_count`=1.
- `i_mode`=1, 12 ticks → rate_sel sequence 0,1,2,3,2,1,0. `o_phase_done` pulses 6 times, `o_sweep_done` pulses once.
- `i_tick` held high for 20 cycles in RUN → exactly 1 tick counted, no phase change.
- Pause mid-phase after 1 tick; pulse `i_tick` 3 times; release pause; apply 1 more tick → phase advances only on that tick. `o_sw[0]` is 0 throughout HOLD.
- Assert `i_stop` and a tick edge together, then `i_start` while busy → stop wins: IDLE, `o_sw`=000. The ignored start does not change state. `o_sweep_count` is retained.
- Force `o_sweep_count` to saturate with NB_SWEEP=2 → it stays at 3 after the 4th sweep. Assert `i_reset` mid-phase → all outputs 0 next cycle.

Source files
------------

// File: rtl/rate_sweep_ctrl_if.sv
// Control/status bundle between the board-side driver and the rate sweep
// sequencer. i_tick is the counter's o_valid: a valid-only strobe with no
// ready/back-pressure; the sequencer counts only its rising edges, so a held
// level is one event. All other inputs are levels sampled every clock.
interface rate_sweep_ctrl_if #(
    parameter int NB_SWEEP = 8
);
    logic                i_start;
    logic                i_stop;
    logic                i_pause;
    logic                i_mode;
    logic                i_tick;
    logic [2:0]          o_sw;
    logic                o_cnt_reset;
    logic                o_busy;
    logic                o_phase_done;
    logic                o_sweep_done;
    logic [NB_SWEEP-1:0] o_sweep_count;
    logic [1:0]          o_state;      // debug view of the sequencer state

    modport master (
        output i_start, i_stop, i_pause, i_mode, i_tick,
        input  o_sw, o_cnt_reset, o_busy, o_phase_done, o_sweep_done,
               o_sweep_count, o_state
    );

    modport slave (
        input  i_start, i_stop, i_pause, i_mode, i_tick,
        output o_sw, o_cnt_reset, o_busy, o_phase_done, o_sweep_done,
               o_sweep_count, o_state
    );
endinterface

// File: rtl/rate_sweep_ctrl.sv
// Rate sweep sequencer: drives the tick counter's {rate_sel, enable} word and
// its reset, stepping rate_sel through a wrap-up or ping-pong sweep after a
// fixed number of counter ticks per rate.
module rate_sweep_ctrl #(
    parameter int TICKS_PER_PHASE = 16,
    parameter int NB_TICKS        = 8,
    parameter int NB_SWEEP        = 8
) (
    input logic             clock,
    input logic             i_reset,
    rate_sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [NB_TICKS-1:0] LAST_TICK = NB_TICKS'(TICKS_PER_PHASE - 1);
    localparam logic [NB_SWEEP-1:0] SWEEP_MAX = '1;

    state_t              state;
    logic [1:0]          rate_sel;
    logic                enable;
    logic                dir_down;
    logic                mode;
    logic                tick_d;
    logic                cnt_reset;
    logic                busy;
    logic                phase_done;
    logic                sweep_done;
    logic [NB_TICKS-1:0] tick_cnt;
    logic [NB_SWEEP-1:0] sweep_count;

    logic                tick_edge;
    logic [1:0]          next_sel;
    logic                next_dir_down;
    logic                returns_to_zero;

    assign tick_edge = bus.i_tick & ~tick_d;

    // Next rate in the latched sweep order; a sweep completes whenever the
    // step lands back on rate 0 (3->0 in wrap-up, 1->0 in ping-pong).
    always_comb begin
        next_sel      = rate_sel + 2'd1;
        next_dir_down = dir_down;
        if (mode) begin
            if (dir_down) begin
                next_sel = rate_sel - 2'd1;
            end
            if (next_sel == 2'd3) begin
                next_dir_down = 1'b1;
            end else if (next_sel == 2'd0) begin
                next_dir_down = 1'b0;
            end
        end
        returns_to_zero = (next_sel == 2'd0);
    end

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= IDLE;
            rate_sel    <= 2'd0;
            enable      <= 1'b0;
            dir_down    <= 1'b0;
            mode        <= 1'b0;
            tick_d      <= 1'b0;
            cnt_reset   <= 1'b0;
            busy        <= 1'b0;
            phase_done  <= 1'b0;
            sweep_done  <= 1'b0;
            tick_cnt    <= '0;
            sweep_count <= '0;
        end else begin
            tick_d     <= bus.i_tick;
            cnt_reset  <= 1'b0;
            phase_done <= 1'b0;
            sweep_done <= 1'b0;
            if (bus.i_stop) begin
                // sweep_count is deliberately kept for readback
                state    <= IDLE;
                rate_sel <= 2'd0;
                enable   <= 1'b0;
                busy     <= 1'b0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.i_start) begin
                            state       <= RUN;
                            rate_sel    <= 2'd0;
                            dir_down    <= 1'b0;
                            mode        <= bus.i_mode;
                            tick_cnt    <= '0;
                            sweep_count <= '0;
                            enable      <= 1'b1;
                            busy        <= 1'b1;
                            cnt_reset   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (bus.i_pause) begin
                            // a tick edge arriving with pause entry is dropped
                            state  <= HOLD;
                            enable <= 1'b0;
                        end else if (tick_edge) begin
                            if (tick_cnt < LAST_TICK) begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end else begin
                                tick_cnt   <= '0;
                                rate_sel   <= next_sel;
                                dir_down   <= next_dir_down;
                                phase_done <= 1'b1;
                                cnt_reset  <= 1'b1;
                                sweep_done <= returns_to_zero;
                                if (returns_to_zero && (sweep_count != SWEEP_MAX)) begin
                                    sweep_count <= sweep_count + 1'b1;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (!bus.i_pause) begin
                            state  <= RUN;
                            enable <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_sw          = {rate_sel, enable};
    assign bus.o_cnt_reset   = cnt_reset;
    assign bus.o_busy        = busy;
    assign bus.o_phase_done  = phase_done;
    assign bus.o_sweep_done  = sweep_done;
    assign bus.o_sweep_count = sweep_count;
    assign bus.o_state       = state;
endmodule

// File: tb/tb_rate_sweep_ctrl.sv
// Bench for rate_sweep_ctrl: directed scenarios plus randomized traffic, all
// compared against a sequence-table model of the sweep.
module tb_rate_sweep_ctrl;
    localparam int TPP       = 2;
    localparam int NB_SWEEP  = 2;
    localparam int SWEEP_MAX = (1 << NB_SWEEP) - 1;

    typedef enum int {M_IDLE, M_RUN, M_HOLD} mstate_t;

    logic clock   = 1'b0;
    logic i_reset = 1'b1;

    rate_sweep_ctrl_if #(.NB_SWEEP(NB_SWEEP)) bus ();

    rate_sweep_ctrl #(
        .TICKS_PER_PHASE(TPP),
        .NB_TICKS       (8),
        .NB_SWEEP       (NB_SWEEP)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .bus    (bus)
    );

    // clock / reset
    always #5 clock = ~clock;

    // checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: the sweep is a position in a rate table
    mstate_t m_state = M_IDLE;
    int      m_pos   = 0;
    int      m_ticks = 0;
    int      m_count = 0;
    int      m_mode  = 0;
    logic    m_tick_prev = 1'b0;
    logic    m_valid = 1'b0;
    logic    m_phase_done = 1'b0;
    logic    m_sweep_done = 1'b0;
    logic    m_cnt_reset  = 1'b0;

    function automatic int seq_len(input int mode);
        return (mode != 0) ? 6 : 4;
    endfunction

    function automatic int rate_at(input int mode, input int pos);
        if (mode == 0) return pos;
        return (pos < 4) ? pos : 6 - pos;
    endfunction

    task automatic model_step(input logic rst, input logic st, input logic sp,
                              input logic ps, input logic md, input logic tk);
        logic edge_now;
        edge_now     = tk && !m_tick_prev;
        m_tick_prev  = rst ? 1'b0 : tk;
        m_phase_done = 1'b0;
        m_sweep_done = 1'b0;
        m_cnt_reset  = 1'b0;
        if (rst) begin
            m_state = M_IDLE; m_pos = 0; m_ticks = 0; m_count = 0; m_mode = 0;
            m_valid = 1'b1;
        end else if (sp) begin
            m_state = M_IDLE; m_pos = 0; m_ticks = 0;
        end else if (m_state == M_IDLE) begin
            if (st) begin
                m_state = M_RUN; m_pos = 0; m_ticks = 0; m_count = 0;
                m_mode = md ? 1 : 0;
                m_cnt_reset = 1'b1;
            end
        end else if (m_state == M_RUN) begin
            if (ps) begin
                m_state = M_HOLD;
            end else if (edge_now) begin
                m_ticks++;
                if (m_ticks == TPP) begin
                    m_ticks = 0;
                    m_pos = (m_pos + 1) % seq_len(m_mode);
                    m_phase_done = 1'b1;
                    m_cnt_reset  = 1'b1;
                    if (rate_at(m_mode, m_pos) == 0) begin
                        m_sweep_done = 1'b1;
                        if (m_count < SWEEP_MAX) m_count++;
                    end
                end
            end
        end else if (!ps) begin
            m_state = M_RUN;
        end
    endtask

    // inputs as the DUT saw them at the last rising edge
    logic s_reset = 1'b1, s_start = 1'b0, s_stop = 1'b0, s_pause = 1'b0, s_mode = 1'b0, s_tick = 1'b0;
    always @(posedge clock) begin
        s_reset <= i_reset;
        s_start <= bus.i_start;
        s_stop  <= bus.i_stop;
        s_pause <= bus.i_pause;
        s_mode  <= bus.i_mode;
        s_tick  <= bus.i_tick;
    end

    // scoreboard: expected o_sw on each phase change of a directed sequence
    logic [2:0] exp_q[$];
    logic       seq_on = 1'b0;
    int         phase_seen = 0;
    int         sweep_seen = 0;
    logic [2:0] exp_sw;

    // per-cycle comparison against the model, sampled mid-cycle
    always @(negedge clock) begin
        model_step(s_reset, s_start, s_stop, s_pause, s_mode, s_tick);
        if (m_valid) begin
            exp_sw = {2'(rate_at(m_mode, m_pos)), m_state == M_RUN};
            check("sw", bus.o_sw, exp_sw);
            check("busy", bus.o_busy, m_state != M_IDLE);
            check("cnt_reset", bus.o_cnt_reset, m_cnt_reset);
            check("phase_done", bus.o_phase_done, m_phase_done);
            check("sweep_done", bus.o_sweep_done, m_sweep_done);
            check("sweep_count", bus.o_sweep_count, m_count);
        end
        if (bus.o_phase_done === 1'b1) begin
            phase_seen++;
            if (seq_on && exp_q.size() > 0) check("seq_sw", bus.o_sw, exp_q.pop_front());
        end
        if (bus.o_sweep_done === 1'b1) sweep_seen++;
    end

    // driver tasks, each called just after a falling edge
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            bus.i_tick = 1'b1;
            @(negedge clock);
            bus.i_tick = 1'b0;
            repeat (4) @(negedge clock);
        end
    endtask

    task automatic do_start(input logic md);
        bus.i_mode  = md;
        bus.i_start = 1'b1;
        @(negedge clock);
        bus.i_start = 1'b0;
    endtask

    task automatic do_stop();
        bus.i_stop = 1'b1;
        @(negedge clock);
        bus.i_stop = 1'b0;
    endtask

    int pbase;
    int sbase;

    initial begin
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_pause = 1'b0;
        bus.i_mode  = 1'b0;
        bus.i_tick  = 1'b0;
        @(negedge clock);
        wait_cycles(2);
        i_reset = 1'b0;
        check("rst_sw", bus.o_sw, 3'b000);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_count", bus.o_sweep_count, 0);
        wait_cycles(2);

        // wrap-up sweep
        do_start(1'b0);
        check("start_sw", bus.o_sw, 3'b001);
        check("start_cnt_reset", bus.o_cnt_reset, 1'b1);
        pbase = phase_seen; sbase = sweep_seen;
        exp_q = '{3'b011, 3'b101, 3'b111, 3'b001};
        seq_on = 1'b1;
        pulse_ticks(8);
        seq_on = 1'b0;
        check("wrap_left", exp_q.size(), 0);
        check("wrap_phases", phase_seen - pbase, 4);
        check("wrap_sweeps", sweep_seen - sbase, 1);
        check("wrap_count", bus.o_sweep_count, 1);

        // ping-pong sweep
        do_stop();
        do_start(1'b1);
        pbase = phase_seen; sbase = sweep_seen;
        exp_q = '{3'b011, 3'b101, 3'b111, 3'b101, 3'b011, 3'b001};
        seq_on = 1'b1;
        pulse_ticks(12);
        seq_on = 1'b0;
        check("pp_left", exp_q.size(), 0);
        check("pp_phases", phase_seen - pbase, 6);
        check("pp_sweeps", sweep_seen - sbase, 1);
        check("pp_count", bus.o_sweep_count, 1);

        // held-high tick counts once
        do_stop();
        do_start(1'b0);
        pbase = phase_seen;
        bus.i_tick = 1'b1;
        wait_cycles(20);
        bus.i_tick = 1'b0;
        wait_cycles(3);
        check("held_phases", phase_seen - pbase, 0);
        check("held_sw", bus.o_sw, 3'b001);
        pulse_ticks(1);
        check("held_next_sw", bus.o_sw, 3'b011);

        // pause mid-phase
        pulse_ticks(1);
        bus.i_pause = 1'b1;
        wait_cycles(2);
        check("hold_sw", bus.o_sw, 3'b010);
        pbase = phase_seen;
        pulse_ticks(3);
        check("hold_phases", phase_seen - pbase, 0);
        check("hold_sw2", bus.o_sw, 3'b010);
        bus.i_pause = 1'b0;
        wait_cycles(2);
        check("resume_sw", bus.o_sw, 3'b011);
        pulse_ticks(1);
        check("resume_adv_sw", bus.o_sw, 3'b101);

        // start while busy is ignored; stop beats a same-cycle tick edge
        pulse_ticks(4);
        check("pre_stop_count", bus.o_sweep_count, 1);
        pulse_ticks(1);
        do_start(1'b1);
        check("busy_start_sw", bus.o_sw, 3'b001);
        check("busy_start_cnt_reset", bus.o_cnt_reset, 1'b0);
        pbase = phase_seen;
        bus.i_stop = 1'b1;
        bus.i_tick = 1'b1;
        @(negedge clock);
        bus.i_stop = 1'b0;
        bus.i_tick = 1'b0;
        check("stop_sw", bus.o_sw, 3'b000);
        check("stop_busy", bus.o_busy, 1'b0);
        check("stop_count", bus.o_sweep_count, 1);
        wait_cycles(3);
        check("stop_phases", phase_seen - pbase, 0);

        // sweep count saturation
        do_start(1'b0);
        sbase = sweep_seen;
        pulse_ticks(8);
        check("sat_count1", bus.o_sweep_count, 1);
        pulse_ticks(16);
        check("sat_count3", bus.o_sweep_count, 3);
        pulse_ticks(8);
        check("sat_count4", bus.o_sweep_count, 3);
        check("sat_sweeps", sweep_seen - sbase, 4);

        // reset mid-phase together with a would-be advancing tick
        pulse_ticks(1);
        i_reset    = 1'b1;
        bus.i_tick = 1'b1;
        @(negedge clock);
        bus.i_tick = 1'b0;
        check("mid_rst_sw", bus.o_sw, 3'b000);
        check("mid_rst_cnt_reset", bus.o_cnt_reset, 1'b0);
        check("mid_rst_busy", bus.o_busy, 1'b0);
        check("mid_rst_phase", bus.o_phase_done, 1'b0);
        check("mid_rst_sweep", bus.o_sweep_done, 1'b0);
        check("mid_rst_count", bus.o_sweep_count, 0);
        i_reset = 1'b0;
        wait_cycles(2);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_reset     = ($urandom_range(0, 299) == 0);
            bus.i_stop  = ($urandom_range(0, 99) < 2);
            bus.i_start = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 99) < 4) bus.i_pause = ~bus.i_pause;
            bus.i_tick  = ($urandom_range(0, 99) < 30);
            bus.i_mode  = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        i_reset     = 1'b0;
        bus.i_stop  = 1'b0;
        bus.i_start = 1'b0;
        bus.i_pause = 1'b0;
        bus.i_tick  = 1'b0;
        wait_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
